mem_transfer_datapath: RTL and testbench
========================================

Name: mem_transfer_datapath

Overview:
- Datapath paired with the memory-to-memory transfer controller.
- Consumes the controller strobes IncA, IncB, WEA and WEB.
- Contains memory A, memory B, their address counters, a pair-hold register and an adder.
- Memory A is loaded from DataIn. Consecutive word pairs of A are summed and written into B. Terminal-count flags are returned to the controller.

Parameters:
- WIDTH, 8, data word width.
- DEPTH_A, 8, words in memory A (power of two).
- AW_A, 3, memory A address width, equal to log2(DEPTH_A).
- DEPTH_B, 4, words in memory B, equal to DEPTH_A/2.
- AW_B, 2, memory B address width, equal to log2(DEPTH_B).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- IncA  in  1  advance AddrA by one at the clock edge.
- IncB  in  1  advance AddrB by one at the clock edge.
- WEA  in  1  write DataIn into memA[AddrA].
- WEB  in  1  write Sum into memB[AddrB].
- DataIn  in  WIDTH  load data for memory A.
- AddrA  out  AW_A  memory A address counter.
- AddrB  out  AW_B  memory B address counter.
- DOutA  out  WIDTH  memA[AddrA], combinational read.
- DOutB  out  WIDTH  memB[AddrB], combinational read.
- Hold  out  WIDTH  captured first word of the current pair.
- Sum  out  WIDTH  (Hold + DOutA) mod 2^WIDTH.
- Carry  out  1  carry-out of Hold + DOutA.
- LastA  out  1  AddrA == DEPTH_A-1.
- LastB  out  1  AddrB == DEPTH_B-1.

Behaviour:
- Reset (asynchronous, active-high):
  - AddrA=0, AddrB=0, Hold=0.
  - Every memA and memB word is cleared to 0.
  - Consequently DOutA=0, DOutB=0, Sum=0, Carry=0, LastA=0, LastB=0.
  - Reset asserted mid-operation aborts at once; no partial write survives.
- Memories: synchronous write, asynchronous read.
  - WEA: memA[AddrA] <= DataIn, using the AddrA value before the edge.
  - WEB: memB[AddrB] <= Sum, using the Hold, DOutA and AddrB values before the edge.
- Counters:
  - IncA: AddrA <= AddrA+1, wrapping DEPTH_A-1 -> 0. IncB behaves the same on AddrB, wrapping DEPTH_B-1 -> 0.
  - With Inc low the counter holds.
  - No saturation and no error flag on wrap.
- Hold register: on every edge with IncA=1, Hold <= DOutA (the word being stepped past). Otherwise Hold keeps its value.
- Sum/Carry: purely combinational from Hold and DOutA, computed as an unsigned WIDTH+1 bit add. Sum takes the low WIDTH bits; Carry takes the MSB.
- Simultaneous events:
  - WEA+IncA: write at the old address, then increment. Hold captures the pre-write DOutA.
  - WEB+IncB: write at the old AddrB, then increment.
  - WEB+IncA: B receives the Sum from before the edge; Hold then updates.
  - WEA+WEB together: both writes occur independently. B gets the old memA contents via Sum.
- Intended controller sequence:
  - Load phase: DEPTH_A cycles of WEA+IncA. AddrA returns to 0 afterwards.
  - Transfer phase, per pair: one cycle of IncA (Hold <= A[2k]), then one cycle of WEB+IncB+IncA (B[k] <= A[2k]+A[2k+1]).
  - LastA/LastB tell the controller when to end each phase.
- Latency: memory read is 0 cycles. A write is visible on DOutA/DOutB in the cycle after the edge, provided the address is unchanged.

Decomposition:
- Shared package mem_transfer_pkg holds:
  - constants WIDTH, DEPTH_A, DEPTH_B, AW_A, AW_B;
  - typedef word_t (WIDTH bits) and typedefs addra_t and addrb_t;
  - so that the controller and the datapath agree on sizes.
- One sub-module is natural: mem_transfer_ram. It is a parameterised (depth, width) async-read, sync-write RAM with asynchronous clear, instantiated twice (memory A and memory B).
- Counters, Hold and the adder stay in the top module.

Test Plan:
- Reset, then 8 cycles of WEA+IncA with DataIn=1..8, then 4×(IncA ; WEB+IncB+IncA) -> memA={1..8}, memB={3,7,11,15}, AddrA=0, AddrB=0, Carry=0 throughout.
- Overflow: load A0=200, A1=100, then IncA ; WEB+IncB+IncA -> Sum=44 and Carry=1 before the write edge, B0=44.
- Wrap and flags: 7 IncA pulses -> AddrA=7, LastA=1; next IncA -> AddrA=0, LastA=0. 3 IncB pulses -> LastB=1; 4th -> AddrB=0.
- Reset mid-transfer: assert Reset after the 2nd B write -> AddrA, AddrB, Hold, all memories and DOutB read 0 immediately, without waiting for a clock edge.
- Simultaneous WEA+WEB with Hold=5, memA[AddrA]=6, DataIn=9 -> memB[AddrB]=11 and memA[AddrA]=9 after the edge. IncA held low -> Hold stays 5.
- Idle cycles with all strobes low -> no counter, Hold or memory change over 10 cycles.

Source files
------------

// File: rtl/mem_transfer_pkg.sv
// Shared sizes and types so the transfer controller and datapath agree on widths.
package mem_transfer_pkg;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned DEPTH_A = 8;
  localparam int unsigned AW_A    = $clog2(DEPTH_A);
  localparam int unsigned DEPTH_B = DEPTH_A / 2;
  localparam int unsigned AW_B    = $clog2(DEPTH_B);

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [AW_A-1:0]  addra_t;
  typedef logic [AW_B-1:0]  addrb_t;
endpackage

// File: rtl/mem_transfer_ram.sv
// Async-read, sync-write RAM whose whole contents clear on asynchronous reset.
module mem_transfer_ram #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/mem_transfer_datapath.sv
// Datapath for memory-to-memory transfer: A is loaded from DataIn, word pairs
// of A are summed into B, and terminal-count flags go back to the controller.
module mem_transfer_datapath
  import mem_transfer_pkg::*;
(
  input  logic   clock,
  input  logic   Reset,
  input  logic   IncA,
  input  logic   IncB,
  input  logic   WEA,
  input  logic   WEB,
  input  word_t  DataIn,
  output addra_t AddrA,
  output addrb_t AddrB,
  output word_t  DOutA,
  output word_t  DOutB,
  output word_t  Hold,
  output word_t  Sum,
  output logic   Carry,
  output logic   LastA,
  output logic   LastB
);
  logic [WIDTH:0] sum_full;

  mem_transfer_ram #(
    .DEPTH(DEPTH_A),
    .WIDTH(WIDTH),
    .AW   (AW_A)
  ) u_mem_a (
    .clock(clock),
    .rst  (Reset),
    .we   (WEA),
    .addr (AddrA),
    .wdata(DataIn),
    .rdata(DOutA)
  );

  mem_transfer_ram #(
    .DEPTH(DEPTH_B),
    .WIDTH(WIDTH),
    .AW   (AW_B)
  ) u_mem_b (
    .clock(clock),
    .rst  (Reset),
    .we   (WEB),
    .addr (AddrB),
    .wdata(Sum),
    .rdata(DOutB)
  );

  // Counters wrap naturally because both depths are powers of two.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      AddrA <= '0;
      AddrB <= '0;
      Hold  <= '0;
    end else begin
      if (IncA) begin
        AddrA <= AddrA + addra_t'(1);
        Hold  <= DOutA;
      end
      if (IncB) AddrB <= AddrB + addrb_t'(1);
    end
  end

  assign sum_full = {1'b0, Hold} + {1'b0, DOutA};
  assign Sum      = sum_full[WIDTH-1:0];
  assign Carry    = sum_full[WIDTH];
  assign LastA    = (AddrA == addra_t'(DEPTH_A - 1));
  assign LastB    = (AddrB == addrb_t'(DEPTH_B - 1));
endmodule

// File: tb/tb_mem_transfer_datapath.sv
// Self-checking bench: table-driven load/transfer, corner sequences, random run.
module tb_mem_transfer_datapath;
  import mem_transfer_pkg::*;

  logic   clock, Reset, IncA, IncB, WEA, WEB;
  word_t  DataIn;
  addra_t AddrA;
  addrb_t AddrB;
  word_t  DOutA, DOutB, Hold, Sum;
  logic   Carry, LastA, LastB;

  int checks = 0;
  int errors = 0;

  // Reference model: plain arrays and modular arithmetic.
  int ma [8];
  int mb [4];
  int m_aa, m_ab, m_hold;

  typedef struct {
    logic ia, ib, wa, wb;
    int   din, addra, addrb, douta, doutb, hold, sum;
  } vec_t;
  vec_t tbl [16];

  mem_transfer_datapath dut (
    .clock (clock),
    .Reset (Reset),
    .IncA  (IncA),
    .IncB  (IncB),
    .WEA   (WEA),
    .WEB   (WEB),
    .DataIn(DataIn),
    .AddrA (AddrA),
    .AddrB (AddrB),
    .DOutA (DOutA),
    .DOutB (DOutB),
    .Hold  (Hold),
    .Sum   (Sum),
    .Carry (Carry),
    .LastA (LastA),
    .LastB (LastB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(logic ia, logic ib, logic wa, logic wb, int din,
                              int a, int b, int da, int db, int h, int s);
    vec_t v;
    v.ia = ia; v.ib = ib; v.wa = wa; v.wb = wb; v.din = din;
    v.addra = a; v.addrb = b; v.douta = da; v.doutb = db; v.hold = h; v.sum = s;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) ma[i] = 0;
    for (int i = 0; i < 4; i++) mb[i] = 0;
    m_aa = 0; m_ab = 0; m_hold = 0;
  endtask

  task automatic model_step(input logic ia, ib, wa, wb, input int d);
    int da, s;
    da = ma[m_aa];
    s  = (m_hold + da) % 256;
    if (wa) ma[m_aa] = d % 256;
    if (wb) mb[m_ab] = s;
    if (ia) begin
      m_hold = da;
      m_aa   = (m_aa + 1) % 8;
    end
    if (ib) m_ab = (m_ab + 1) % 4;
  endtask

  task automatic check_all(input string tag);
    int tot;
    tot = m_hold + ma[m_aa];
    chk({tag, "_addra"}, int'(AddrA), m_aa);
    chk({tag, "_addrb"}, int'(AddrB), m_ab);
    chk({tag, "_douta"}, int'(DOutA), ma[m_aa]);
    chk({tag, "_doutb"}, int'(DOutB), mb[m_ab]);
    chk({tag, "_hold"},  int'(Hold),  m_hold);
    chk({tag, "_sum"},   int'(Sum),   tot % 256);
    chk({tag, "_carry"}, int'(Carry), (tot > 255) ? 1 : 0);
    chk({tag, "_lasta"}, int'(LastA), (m_aa == 7) ? 1 : 0);
    chk({tag, "_lastb"}, int'(LastB), (m_ab == 3) ? 1 : 0);
  endtask

  // Drive strobes, compare combinational outputs mid-cycle, then clock once.
  task automatic step(input logic ia, ib, wa, wb, input int d);
    IncA = ia; IncB = ib; WEA = wa; WEB = wb; DataIn = 8'(d);
    @(negedge clock);
    check_all("pre");
    @(posedge clock);
    model_step(ia, ib, wa, wb, d);
    #1;
  endtask

  task automatic do_reset();
    IncA = 0; IncB = 0; WEA = 0; WEB = 0; DataIn = '0;
    Reset = 1'b1;
    #2;
    model_reset();
    check_all("rst");
    @(posedge clock);
    #1;
    Reset = 1'b0;
    #1;
  endtask

  task automatic load_seq();
    for (int i = 0; i < 8; i++) step(1, 0, 1, 0, i + 1);
  endtask

  initial begin
    Reset = 1'b1; IncA = 0; IncB = 0; WEA = 0; WEB = 0; DataIn = '0;

    // Expected state after each step: load 1..8 then four pair transfers.
    tbl[0]  = mk(1,0,1,0,1, 1,0,0,0,0,0);
    tbl[1]  = mk(1,0,1,0,2, 2,0,0,0,0,0);
    tbl[2]  = mk(1,0,1,0,3, 3,0,0,0,0,0);
    tbl[3]  = mk(1,0,1,0,4, 4,0,0,0,0,0);
    tbl[4]  = mk(1,0,1,0,5, 5,0,0,0,0,0);
    tbl[5]  = mk(1,0,1,0,6, 6,0,0,0,0,0);
    tbl[6]  = mk(1,0,1,0,7, 7,0,0,0,0,0);
    tbl[7]  = mk(1,0,1,0,8, 0,0,1,0,0,1);
    tbl[8]  = mk(1,0,0,0,0, 1,0,2,0,1,3);
    tbl[9]  = mk(1,1,0,1,0, 2,1,3,0,2,5);
    tbl[10] = mk(1,0,0,0,0, 3,1,4,0,3,7);
    tbl[11] = mk(1,1,0,1,0, 4,2,5,0,4,9);
    tbl[12] = mk(1,0,0,0,0, 5,2,6,0,5,11);
    tbl[13] = mk(1,1,0,1,0, 6,3,7,0,6,13);
    tbl[14] = mk(1,0,0,0,0, 7,3,8,0,7,15);
    tbl[15] = mk(1,1,0,1,0, 0,0,1,3,8,9);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].ia, tbl[i].ib, tbl[i].wa, tbl[i].wb, tbl[i].din);
      chk($sformatf("tbl%0d_addra", i), int'(AddrA), tbl[i].addra);
      chk($sformatf("tbl%0d_addrb", i), int'(AddrB), tbl[i].addrb);
      chk($sformatf("tbl%0d_douta", i), int'(DOutA), tbl[i].douta);
      chk($sformatf("tbl%0d_doutb", i), int'(DOutB), tbl[i].doutb);
      chk($sformatf("tbl%0d_hold", i),  int'(Hold),  tbl[i].hold);
      chk($sformatf("tbl%0d_sum", i),   int'(Sum),   tbl[i].sum);
      chk($sformatf("tbl%0d_carry", i), int'(Carry), 0);
    end
    // Read back B by stepping AddrB through a full wrap.
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("memb%0d", k), int'(DOutB), 4 * k + 3);
      step(0, 1, 0, 0, 0);
    end
    chk("memb_wrap", int'(DOutB), 3);

    // Carry out of the pair adder.
    do_reset();
    step(1, 0, 1, 0, 200);
    step(1, 0, 1, 0, 100);
    repeat (6) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("ovf_sum", int'(Sum), 44);
    chk("ovf_carry", int'(Carry), 1);
    step(1, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("lastb_set", int'(LastB), 1);
    step(0, 1, 0, 0, 0);
    chk("addrb_wrap", int'(AddrB), 0);
    chk("lastb_clr", int'(LastB), 0);
    chk("ovf_b0", int'(DOutB), 44);

    // AddrA terminal count and wrap.
    do_reset();
    repeat (7) step(1, 0, 0, 0, 0);
    chk("lasta_addr", int'(AddrA), 7);
    chk("lasta_set", int'(LastA), 1);
    step(1, 0, 0, 0, 0);
    chk("addra_wrap", int'(AddrA), 0);
    chk("lasta_clr", int'(LastA), 0);

    // Asynchronous reset in the middle of a transfer.
    do_reset();
    load_seq();
    repeat (2) begin
      step(1, 0, 0, 0, 0);
      step(1, 1, 0, 1, 0);
    end
    IncA = 1; IncB = 1; WEA = 1; WEB = 1; DataIn = 8'd77;
    #2;
    Reset = 1'b1;
    #1;
    model_reset();
    chk("mid_addra", int'(AddrA), 0);
    chk("mid_addrb", int'(AddrB), 0);
    chk("mid_hold",  int'(Hold),  0);
    chk("mid_douta", int'(DOutA), 0);
    chk("mid_doutb", int'(DOutB), 0);
    @(posedge clock);
    #1;
    Reset = 1'b0;
    repeat (8) step(1, 0, 0, 0, 0);
    repeat (4) step(0, 1, 0, 0, 0);

    // Simultaneous writes to A and B without advancing.
    do_reset();
    step(1, 0, 1, 0, 5);
    step(1, 0, 1, 0, 6);
    repeat (6) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 9);
    chk("sim_doutb", int'(DOutB), 11);
    chk("sim_douta", int'(DOutA), 9);
    chk("sim_hold",  int'(Hold),  5);

    // Idle: nothing moves.
    repeat (10) step(0, 0, 0, 0, $urandom_range(0, 255));
    chk("idle_addra", int'(AddrA), 1);
    chk("idle_addrb", int'(AddrB), 0);
    chk("idle_hold",  int'(Hold),  5);
    chk("idle_douta", int'(DOutA), 9);
    chk("idle_doutb", int'(DOutB), 11);

    // Random strobes against the model, with occasional resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 63) == 0) do_reset();
      else step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 255)));
    end
    @(negedge clock);
    check_all("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
